// File: rtl/aes_decrypt_core.sv
// AES-128 iterative decryption core: ten forward key steps recover round key 10,
// then ten inverse rounds walk the key schedule backwards while decrypting.
package aes_dec_pkg;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x;
      logic [7:0] r;
      x = gf_mul(a, a);
      r = x;
      for (int k = 2; k < 8; k++) begin
         x = gf_mul(x, x);
         r = gf_mul(r, x);
      end
      return r;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      s0 = c[31:24];
      s1 = c[23:16];
      s2 = c[15:8];
      s3 = c[7:0];
      return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
              gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
              gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
              gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   import aes_dec_pkg::*;
   logic [7:0] w_inv;
   assign w_inv  = gf_inv(i_byte);
   assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   import aes_dec_pkg::*;
   logic [7:0] w_pre;
   assign w_pre  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
                 ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
   assign o_byte = gf_inv(w_pre);
endmodule

module aes_decrypt_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [127:0] data_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] data_out
);
   import aes_dec_pkg::*;

   typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_DEC} state_t;

   state_t       r_state;
   state_t       w_state_next;
   logic [3:0]   r_rnd;
   logic [127:0] r_rk;
   logic [127:0] r_st;
   logic [127:0] r_data_out;
   logic         r_done;
   logic         w_accept;
   logic         w_kexp_last;
   logic         w_dec_last;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_v3, w_rot, w_sub, w_rcw;
   logic [31:0]  w_f0, w_f1, w_f2, w_f3;
   logic [127:0] w_rk_fwd, w_rk_inv;
   logic [127:0] w_isr, w_isb, w_ark, w_st_dec;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_kexp_last  = 1'b0;
      w_dec_last   = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_KEYEXP;
            end
         end
         S_KEYEXP: begin
            busy = 1'b1;
            if (r_rnd == 4'd10) begin
               w_kexp_last  = 1'b1;
               w_state_next = S_DEC;
            end
         end
         S_DEC: begin
            busy = 1'b1;
            if (r_rnd == 4'd1) begin
               w_dec_last   = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // One set of four S-boxes serves both directions: RotWord(w3) forward, RotWord(w3^w2) inverse.
   assign w_w0  = r_rk[127:96];
   assign w_w1  = r_rk[95:64];
   assign w_w2  = r_rk[63:32];
   assign w_w3  = r_rk[31:0];
   assign w_v3  = w_w3 ^ w_w2;
   assign w_rot = (r_state == S_DEC) ? {w_v3[23:0], w_v3[31:24]} : {w_w3[23:0], w_w3[31:24]};
   assign w_rcw = {rcon(r_rnd), 24'h000000};

   for (genvar g = 0; g < 4; g++) begin : g_key_sbox
      aes_sbox u_sbox (.i_byte(w_rot[31-8*g -: 8]), .o_byte(w_sub[31-8*g -: 8]));
   end

   assign w_f0     = w_w0 ^ w_sub ^ w_rcw;
   assign w_f1     = w_w1 ^ w_f0;
   assign w_f2     = w_w2 ^ w_f1;
   assign w_f3     = w_w3 ^ w_f2;
   assign w_rk_fwd = {w_f0, w_f1, w_f2, w_f3};
   assign w_rk_inv = {w_w0 ^ w_sub ^ w_rcw, w_w1 ^ w_w0, w_w2 ^ w_w1, w_v3};

   // Row r of the column-major state moves right by r columns.
   for (genvar r = 0; r < 4; r++) begin : g_isr_row
      for (genvar c = 0; c < 4; c++) begin : g_isr_col
         localparam int DST = 4*c + r;
         localparam int SRC = 4*((c + 4 - r) % 4) + r;
         assign w_isr[127-8*DST -: 8] = r_st[127-8*SRC -: 8];
      end
   end

   for (genvar b = 0; b < 16; b++) begin : g_inv_sbox
      aes_inv_sbox u_isbox (.i_byte(w_isr[127-8*b -: 8]), .o_byte(w_isb[127-8*b -: 8]));
   end

   assign w_ark    = w_isb ^ w_rk_inv;
   assign w_st_dec = w_dec_last ? w_ark : inv_mix(w_ark);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rnd      <= 4'd0;
         r_rk       <= '0;
         r_st       <= '0;
         r_data_out <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_rk  <= key_in;
            r_st  <= data_in;
            r_rnd <= 4'd1;
         end else if (r_state == S_KEYEXP) begin
            r_rk <= w_rk_fwd;
            if (w_kexp_last) begin
               r_st  <= r_st ^ w_rk_fwd;
               r_rnd <= 4'd10;
            end else begin
               r_rnd <= r_rnd + 4'd1;
            end
         end else if (r_state == S_DEC) begin
            r_rk  <= w_rk_inv;
            r_st  <= w_st_dec;
            r_rnd <= r_rnd - 4'd1;
            if (w_dec_last) begin
               r_data_out <= w_st_dec;
               r_done     <= 1'b1;
            end
         end
      end
   end

   assign done     = r_done;
   assign data_out = r_data_out;

endmodule
